// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-master data RAM arbiter.
package ram_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_SEL_W  = 4;

endpackage

// File: rtl/ram_arb_if.sv
// Bus bundle between the two masters, the arbiter and the data RAM.
interface ram_arb_if
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int SEL_W  = DEF_SEL_W
);
    logic              m0_req_i;
    logic              m0_we_i;
    logic [ADDR_W-1:0] m0_addr_i;
    logic [DATA_W-1:0] m0_data_i;
    logic [SEL_W-1:0]  m0_sel_i;
    logic              m0_gnt_o;
    logic              m0_stall_o;
    logic              m0_rvalid_o;
    logic [DATA_W-1:0] m0_data_o;

    logic              m1_req_i;
    logic              m1_we_i;
    logic [ADDR_W-1:0] m1_addr_i;
    logic [DATA_W-1:0] m1_data_i;
    logic [SEL_W-1:0]  m1_sel_i;
    logic              m1_lock_i;
    logic              m1_gnt_o;
    logic              m1_rvalid_o;
    logic [DATA_W-1:0] m1_data_o;

    logic              ram_ce_o;
    logic              ram_we_o;
    logic [ADDR_W-1:0] ram_addr_o;
    logic [SEL_W-1:0]  ram_sel_o;
    logic [DATA_W-1:0] ram_data_o;
    logic [DATA_W-1:0] ram_data_i;

    // Arbiter side
    modport slave (
        input  m0_req_i, m0_we_i, m0_addr_i, m0_data_i, m0_sel_i,
        output m0_gnt_o, m0_stall_o, m0_rvalid_o, m0_data_o,
        input  m1_req_i, m1_we_i, m1_addr_i, m1_data_i, m1_sel_i, m1_lock_i,
        output m1_gnt_o, m1_rvalid_o, m1_data_o,
        output ram_ce_o, ram_we_o, ram_addr_o, ram_sel_o, ram_data_o,
        input  ram_data_i
    );

    // Masters plus RAM side
    modport master (
        output m0_req_i, m0_we_i, m0_addr_i, m0_data_i, m0_sel_i,
        input  m0_gnt_o, m0_stall_o, m0_rvalid_o, m0_data_o,
        output m1_req_i, m1_we_i, m1_addr_i, m1_data_i, m1_sel_i, m1_lock_i,
        input  m1_gnt_o, m1_rvalid_o, m1_data_o,
        input  ram_ce_o, ram_we_o, ram_addr_o, ram_sel_o, ram_data_o,
        output ram_data_i
    );

endinterface

// File: rtl/ram_arb_rr.sv
// Two-way grant pick with last-winner pointer; RAM_ARB_FIXED_PRIO_EN makes M0 always win.
module ram_arb_rr
    import ram_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       lock,
    output logic [1:0] gnt
);

`ifdef RAM_ARB_FIXED_PRIO_EN
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;

    always_comb begin
        gnt = 2'b00;
        if (lock) begin
            gnt[1] = req[1];
        end else if (req[0]) begin
            gnt[0] = 1'b1;
        end else begin
            gnt[1] = req[1];
        end
    end
`else
    logic last_gnt;

    always_comb begin
        gnt = 2'b00;
        if (lock) begin
            gnt[1] = req[1];
        end else if (&req) begin
            if (last_gnt == M1) gnt[0] = 1'b1;
            else                gnt[1] = 1'b1;
        end else begin
            gnt = req;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt <= M1;
        end else if (|gnt) begin
            last_gnt <= gnt[1] ? M1 : M0;
        end
    end
`endif

endmodule

// File: rtl/ram_arbiter.sv
// Shares one synchronous-read data RAM between M0 (CPU) and M1 (DMA) with an M1 burst lock.
// Optional macro RAM_ARB_FIXED_PRIO_EN: M0 always wins an unlocked conflict.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int SEL_W    = DEF_SEL_W,
    parameter int LOCK_MAX = 16
) (
    input  logic     clk,
    input  logic     rst,
    ram_arb_if.slave bus
);

    localparam int               CNT_W   = $clog2(LOCK_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_MAX);

    arb_state_t       state, state_nx;
    logic [CNT_W-1:0] lock_cnt, lock_cnt_nx, cnt_inc;
    logic [1:0]       req, gnt;
    logic             locked;
    logic             rvld0_p1, rvld1_p1;

    assign req    = {bus.m1_req_i, bus.m0_req_i};
    assign locked = (state == LOCK);

    ram_arb_rr u_rr (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .lock (locked),
        .gnt  (gnt)
    );

    assign bus.m0_gnt_o   = gnt[0];
    assign bus.m1_gnt_o   = gnt[1];
    assign bus.m0_stall_o = bus.m0_req_i & ~gnt[0];

    always_comb begin
        bus.ram_ce_o   = |gnt;
        bus.ram_we_o   = 1'b0;
        bus.ram_addr_o = {ADDR_W{1'b0}};
        bus.ram_sel_o  = {SEL_W{1'b0}};
        bus.ram_data_o = {DATA_W{1'b0}};
        if (gnt[0]) begin
            bus.ram_we_o   = bus.m0_we_i;
            bus.ram_addr_o = bus.m0_addr_i;
            bus.ram_sel_o  = bus.m0_sel_i;
            bus.ram_data_o = bus.m0_data_i;
        end else if (gnt[1]) begin
            bus.ram_we_o   = bus.m1_we_i;
            bus.ram_addr_o = bus.m1_addr_i;
            bus.ram_sel_o  = bus.m1_sel_i;
            bus.ram_data_o = bus.m1_data_i;
        end
    end

    // Stage p1: RAM read data returns one cycle after the accepted read
    always_ff @(posedge clk) begin
        if (rst) begin
            rvld0_p1 <= 1'b0;
            rvld1_p1 <= 1'b0;
        end else begin
            rvld0_p1 <= gnt[0] & ~bus.m0_we_i;
            rvld1_p1 <= gnt[1] & ~bus.m1_we_i;
        end
    end

    assign bus.m0_rvalid_o = rvld0_p1;
    assign bus.m1_rvalid_o = rvld1_p1;
    assign bus.m0_data_o   = rvld0_p1 ? bus.ram_data_i : {DATA_W{1'b0}};
    assign bus.m1_data_o   = rvld1_p1 ? bus.ram_data_i : {DATA_W{1'b0}};

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            lock_cnt <= '0;
        end else begin
            state    <= state_nx;
            lock_cnt <= lock_cnt_nx;
        end
    end

    // lock_cnt counts locked M1 grants issued so far, including the one that
    // entered LOCK; the grant bringing it to LOCK_MAX is the last of the burst.
    always_comb begin
        state_nx    = state;
        lock_cnt_nx = lock_cnt;
        cnt_inc     = lock_cnt + CNT_ONE;
        if (state == IDLE) begin
            lock_cnt_nx = '0;
            if (gnt[1] && bus.m1_lock_i && (CNT_ONE != CNT_MAX)) begin
                state_nx    = LOCK;
                lock_cnt_nx = CNT_ONE;
            end
        end else begin
            if (!bus.m1_lock_i || (gnt[1] && (cnt_inc == CNT_MAX))) begin
                state_nx    = IDLE;
                lock_cnt_nx = '0;
            end else if (gnt[1]) begin
                lock_cnt_nx = cnt_inc;
            end
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: stimulus queues expected per-cycle outputs, a negedge monitor checks them.
module tb_ram_arbiter;

`ifdef RAM_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    localparam logic [31:0] A0 = 32'h10;
    localparam logic [31:0] A1 = 32'h20;
    localparam logic [31:0] D1 = 32'h1234_5678;

    typedef struct {
        int          n;
        logic [4:0]  ctl;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sel;
        logic [1:0]  rv;
        logic [31:0] d0;
        logic [31:0] d1;
        logic        mchk;
        logic [31:0] mexp;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic preload;
    always #5 clk = ~clk;

    ram_arb_if #(.ADDR_W(32), .DATA_W(32), .SEL_W(4)) bus ();

    ram_arbiter #(.ADDR_W(32), .DATA_W(32), .SEL_W(4), .LOCK_MAX(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] mem    [256];
    logic [31:0] shadow [256];
    exp_t        exp_q  [$];
    int          n_chk = 0;
    int          n_pass = 0;
    int          cyc_n = 0;
    logic        prev_rst = 1'b1;
    logic        prev_rd0 = 1'b0;
    logic        prev_rd1 = 1'b0;
    logic [31:0] prev_dat0 = '0;
    logic [31:0] prev_dat1 = '0;
    logic        mchk_pending = 1'b0;

    // Synchronous-read RAM model
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
            mem[8'h10]     <= 32'hDEAD_BEEF;
            bus.ram_data_i <= 32'h0;
        end else if (bus.ram_ce_o) begin
            if (bus.ram_we_o) begin
                for (int b = 0; b < 4; b++)
                    if (bus.ram_sel_o[b])
                        mem[bus.ram_addr_o[7:0]][8*b +: 8] <= bus.ram_data_o[8*b +: 8];
            end else begin
                bus.ram_data_i <= mem[bus.ram_addr_o[7:0]];
            end
        end
    end

    task automatic chk(input string nm, input int n, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp)
            $display("FAIL %s cycle %0d: got %h expected %h", nm, n, act, exp);
        else
            n_pass++;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("gnt1_gnt0_stall_ce_we", e.n,
                32'({bus.m1_gnt_o, bus.m0_gnt_o, bus.m0_stall_o, bus.ram_ce_o, bus.ram_we_o}), 32'(e.ctl));
            chk("ram_addr", e.n, bus.ram_addr_o, e.addr);
            chk("ram_wdata", e.n, bus.ram_data_o, e.wdata);
            chk("ram_sel", e.n, 32'(bus.ram_sel_o), 32'(e.sel));
            chk("rvalid1_rvalid0", e.n, 32'({bus.m1_rvalid_o, bus.m0_rvalid_o}), 32'(e.rv));
            chk("m0_data", e.n, bus.m0_data_o, e.d0);
            chk("m1_data", e.n, bus.m1_data_o, e.d1);
            if (e.mchk) chk("ram_mem_0x20", e.n, mem[8'h20], e.mexp);
        end
    end

    // One clock of stimulus; eg is the hand-derived expected {m1_gnt, m0_gnt}.
    task automatic cyc(input logic r,
                       input logic q0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                       input logic q1, input logic w1, input logic [31:0] a1, input logic [31:0] d1,
                       input logic lk, input logic [1:0] eg);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r;
        bus.m0_req_i = q0; bus.m0_we_i = w0; bus.m0_addr_i = a0; bus.m0_data_i = d0; bus.m0_sel_i = 4'hF;
        bus.m1_req_i = q1; bus.m1_we_i = w1; bus.m1_addr_i = a1; bus.m1_data_i = d1; bus.m1_sel_i = 4'hF;
        bus.m1_lock_i = lk;
        e.n     = cyc_n;
        e.ctl   = {eg[1], eg[0], q0 & ~eg[0], |eg, eg[0] ? w0 : (eg[1] ? w1 : 1'b0)};
        e.addr  = eg[0] ? a0 : (eg[1] ? a1 : 32'h0);
        e.wdata = eg[0] ? d0 : (eg[1] ? d1 : 32'h0);
        e.sel   = (|eg) ? 4'hF : 4'h0;
        e.rv    = {prev_rd1 & ~prev_rst, prev_rd0 & ~prev_rst};
        e.d0    = e.rv[0] ? prev_dat0 : 32'h0;
        e.d1    = e.rv[1] ? prev_dat1 : 32'h0;
        e.mchk  = mchk_pending;
        e.mexp  = shadow[8'h20];
        mchk_pending = 1'b0;
        prev_rd0  = eg[0] & ~w0;
        prev_rd1  = eg[1] & ~w1;
        prev_dat0 = shadow[a0[7:0]];
        prev_dat1 = shadow[a1[7:0]];
        if (eg[0] && w0) shadow[a0[7:0]] = d0;
        if (eg[1] && w1) shadow[a1[7:0]] = d1;
        prev_rst = r;
        exp_q.push_back(e);
        cyc_n++;
    endtask

    task automatic rst_cyc();
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 2'b00);
    endtask

    task automatic idle_cyc();
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 2'b00);
    endtask

    initial begin
        logic [1:0] eg;
        logic       q1;
        rst = 1'b1;
        preload = 1'b1;
        bus.m0_req_i = 1'b0; bus.m0_we_i = 1'b0; bus.m0_addr_i = '0; bus.m0_data_i = '0; bus.m0_sel_i = '0;
        bus.m1_req_i = 1'b0; bus.m1_we_i = 1'b0; bus.m1_addr_i = '0; bus.m1_data_i = '0; bus.m1_sel_i = '0;
        bus.m1_lock_i = 1'b0;
        for (int i = 0; i < 256; i++) shadow[i] = 32'h0;
        shadow[8'h10] = 32'hDEAD_BEEF;
        repeat (2) @(posedge clk);
        #1 preload = 1'b0;

        // 1: lone M0 read, data one cycle later
        rst_cyc(); rst_cyc();
        cyc(1'b0, 1'b1, 1'b0, A0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 2'b01);
        idle_cyc();

        // 2: continuous conflict, M0 reads and M1 writes
        rst_cyc(); rst_cyc();
        for (int i = 0; i < 8; i++) begin
            eg = (FIXED || (i % 2 == 0)) ? 2'b01 : 2'b10;
            cyc(1'b0, 1'b1, 1'b0, A0, 32'h0, 1'b1, 1'b1, A1, D1, 1'b0, eg);
        end
        idle_cyc();
        mchk_pending = 1'b1;
        idle_cyc();

        // 3: M1 burst lock against a persistent M0 request
        rst_cyc(); rst_cyc();
        for (int i = 0; i < 20; i++) begin
            eg = (FIXED || i == 0 || i == 17) ? 2'b01 : 2'b10;
            cyc(1'b0, 1'b1, 1'b0, A0, 32'h0, 1'b1, 1'b0, A1, 32'h0, 1'b1, eg);
        end

        // 4: locked M1 pauses its requests for three cycles
        rst_cyc(); rst_cyc();
        for (int i = 0; i <= 20; i++) begin
            q1 = !(i >= 4 && i <= 6);
            if (FIXED || i == 0 || i == 20) eg = 2'b01;
            else if (i >= 4 && i <= 6)      eg = 2'b00;
            else                            eg = 2'b10;
            cyc(1'b0, 1'b1, 1'b0, A0, 32'h0, q1, 1'b0, A1, 32'h0, 1'b1, eg);
        end

        // 5: reset around accepted reads
        rst_cyc();
        cyc(1'b0, 1'b1, 1'b0, A0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 2'b01);
        cyc(1'b1, 1'b1, 1'b0, A0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 2'b01);
        idle_cyc();
        cyc(1'b0, 1'b1, 1'b0, A0, 32'h0, 1'b1, 1'b0, A1, 32'h0, 1'b0, 2'b01);
        idle_cyc();

        // 6: unlocked conflict for four cycles
        rst_cyc(); rst_cyc();
        for (int i = 0; i < 4; i++) begin
            eg = (FIXED || (i % 2 == 0)) ? 2'b01 : 2'b10;
            cyc(1'b0, 1'b1, 1'b0, A0, 32'h0, 1'b1, 1'b0, A1, 32'h0, 1'b0, eg);
        end
        idle_cyc();
        idle_cyc();

        @(posedge clk);
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
